// File: rtl/sr_cell_access_ctrl.sv
// Word-level request sequencer for a set/reset cell array: strobes one cell's set or
// clear input, samples the cell back and returns data/error over a valid/ready channel.
module sr_cell_access_ctrl #(
  parameter int NBITS         = 2,
  parameter int AW            = 1,
  parameter int PULSE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic             req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_data,
  output logic             rsp_error,
  output logic [NBITS-1:0] cell_set,
  output logic [NBITS-1:0] cell_clr,
  input  logic [NBITS-1:0] cell_q
);

  localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int AWP     = AW + 1;

  localparam logic [CW-1:0]    PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]    SETTLE_LOAD = CW'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [AW:0]      NBITS_W     = AWP'(NBITS);
  localparam logic [NBITS-1:0] ONE         = NBITS'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_write;
  logic             r_data;
  logic [AW-1:0]    r_addr;
  logic [CW-1:0]    r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_rsp_data;
  logic             r_rsp_error;
  logic [NBITS-1:0] r_cell_set;
  logic [NBITS-1:0] r_cell_clr;

  logic             w_in_range;
  logic [NBITS-1:0] w_req_onehot;
  logic [NBITS-1:0] w_addr_onehot;
  logic             w_q_sel;

  // Address decode; an out-of-range latched address selects no cell at all.
  always_comb begin
    w_in_range    = ({1'b0, req_addr} < NBITS_W);
    w_req_onehot  = ONE << req_addr;
    w_addr_onehot = ONE << r_addr;
    w_q_sel       = |(cell_q & w_addr_onehot);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_data      <= 1'b0;
      r_addr      <= {AW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 1'b0;
      r_rsp_error <= 1'b0;
      r_cell_set  <= {NBITS{1'b0}};
      r_cell_clr  <= {NBITS{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_data      <= req_data;
            r_req_ready <= 1'b0;
            if (!w_in_range) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 1'b0;
              r_rsp_error <= 1'b1;
              r_state     <= S_RESP;
            end else if (req_write) begin
              r_cell_set <= req_data ? w_req_onehot : {NBITS{1'b0}};
              r_cell_clr <= req_data ? {NBITS{1'b0}} : w_req_onehot;
              r_cnt      <= PULSE_LOAD;
              r_state    <= S_PULSE;
            end else begin
              r_state <= S_SAMPLE;
            end
          end
        end
        S_PULSE: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_cell_set <= {NBITS{1'b0}};
            r_cell_clr <= {NBITS{1'b0}};
            if (SETTLE_CYCLES > 0) begin
              r_cnt   <= SETTLE_LOAD;
              r_state <= S_SETTLE;
            end else begin
              r_state <= S_SAMPLE;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SETTLE: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SAMPLE: begin
          r_rsp_data  <= w_q_sel;
          r_rsp_error <= r_write & (w_q_sel != r_data);
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_cell_set  <= {NBITS{1'b0}};
          r_cell_clr  <= {NBITS{1'b0}};
        end
      endcase
    end
  end

  // The ready register holds its idle value through reset, so mask it while reset is high.
  assign req_ready = r_req_ready & ~reset;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_error = r_rsp_error;
  assign cell_set  = r_cell_set;
  assign cell_clr  = r_cell_clr;

endmodule
